// File: rtl/log_pkg.sv
// Shared definitions for the log_pipe logic unit: opcode encoding and default widths.
package log_pkg;

    localparam int OP_W          = 3;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [OP_W-1:0] {
        OP_NOT = 3'b000,
        OP_AND = 3'b001,
        OP_OR  = 3'b010,
        OP_XOR = 3'b011,
        OP_MAX = 3'b100,
        OP_EQU = 3'b101,
        OP_MIN = 3'b110,
        OP_RSV = 3'b111
    } op_e;

endpackage

// File: rtl/log_core.sv
// Combinational result/flag computation for one log_pipe beat.
// Sits between the S1 operand registers and the S2 result registers.
module log_core
    import log_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic [WIDTH-1:0] result_o,
    output logic             flag_o,
    output logic             err_o
);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    a_gt_b;
    logic                    a_lt_b;

    assign a_s = a_i;
    assign b_s = b_i;

    // One comparator pair serves both MAX and MIN; signedness only changes the compare.
    always_comb begin
        a_gt_b = 1'b0;
        a_lt_b = 1'b0;
        if (signed_i) begin
            a_gt_b = (a_s > b_s);
            a_lt_b = (a_s < b_s);
        end else begin
            a_gt_b = (a_i > b_i);
            a_lt_b = (a_i < b_i);
        end
    end

    always_comb begin
        result_o = '0;
        flag_o   = 1'b0;
        err_o    = 1'b0;
        case (op_e'(op_i))
            OP_NOT: result_o = ~a_i;
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_MAX: begin
                result_o = a_gt_b ? a_i : b_i;
                flag_o   = a_gt_b;
            end
            OP_EQU: begin
                result_o = a_i;
                flag_o   = (a_i == b_i);
            end
            OP_MIN: begin
                result_o = a_lt_b ? a_i : b_i;
                flag_o   = a_lt_b;
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/log_pipe.sv
// Two-stage valid/ready logic unit (NOT/AND/OR/XOR/MAX/MIN/EQU).
// Optional LOG_SIGNED_EN: i_signed selects signed compare for MAX/MIN.
module log_pipe
    import log_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_flag,
    output logic             o_zero,
    output logic             o_err
);

    logic             s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]  s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s1_signed;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic             s2_flag_q, s2_flag_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_err_q, s2_err_d;

    logic             s2_adv;
    logic             s1_to_s2;
    logic             in_fire;

    logic [WIDTH-1:0] core_result;
    logic             core_flag;
    logic             core_err;

    // S2 frees up when empty or being drained; S1 frees up when empty or moving into S2.
    assign s2_adv   = !s2_valid_q || i_ready;
    assign s1_to_s2 = s1_valid_q && s2_adv;
    assign o_ready  = !s1_valid_q || s2_adv;
    assign in_fire  = i_valid && o_ready;

    // ---- S1: operand capture ----
    always_ff @(posedge i_clk) begin
        if (in_fire) begin
            s1_op_q <= i_op;
            s1_a_q  <= i_a;
            s1_b_q  <= i_b;
        end
    end

`ifdef LOG_SIGNED_EN
    logic s1_signed_q;

    always_ff @(posedge i_clk) begin
        if (in_fire) begin
            s1_signed_q <= i_signed;
        end
    end

    assign s1_signed = s1_signed_q;
`else
    logic unused_signed;

    assign unused_signed = i_signed;
    assign s1_signed     = 1'b0;
`endif

    log_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op_i    (s1_op_q),
        .a_i     (s1_a_q),
        .b_i     (s1_b_q),
        .signed_i(s1_signed),
        .result_o(core_result),
        .flag_o  (core_flag),
        .err_o   (core_err)
    );

    // ---- S2: result registers, next-state ----
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flag_d   = s2_flag_q;
        s2_zero_d   = s2_zero_q;
        s2_err_d    = s2_err_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s1_to_s2) begin
            s1_valid_d = 1'b0;
        end

        // Data is only replaced by a real beat, so a drained S2 keeps its last values.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = core_result;
                s2_flag_d   = core_flag;
                s2_zero_d   = (core_result == '0);
                s2_err_d    = core_err;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flag_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_err_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flag_q   <= s2_flag_d;
            s2_zero_q   <= s2_zero_d;
            s2_err_q    <= s2_err_d;
        end
    end

    assign o_valid  = s2_valid_q;
    assign o_result = s2_result_q;
    assign o_flag   = s2_flag_q;
    assign o_zero   = s2_zero_q;
    assign o_err    = s2_err_q;

endmodule

// File: tb/tb_log_pipe.sv
// Directed self-checking bench for log_pipe (WIDTH=8).
module tb_log_pipe;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic [2:0] i_op;
    logic [7:0] i_a;
    logic [7:0] i_b;
    logic       i_signed;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_result;
    logic       o_flag;
    logic       o_zero;
    logic       o_err;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    log_pipe #(.WIDTH(8)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_signed(i_signed),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_result(o_result),
        .o_flag  (o_flag),
        .o_zero  (o_zero),
        .o_err   (o_err)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_op = 3'b000; i_a = 8'h00; i_b = 8'h00; i_signed = 1'b0;
        tick(); tick();
        i_rst = 1'b0;
        total++;
        if (o_valid !== 1'b0 || o_result !== 8'h00 || o_flag !== 1'b0 || o_zero !== 1'b0 || o_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b r=%h f=%b z=%b e=%b, want all 0", o_valid, o_result, o_flag, o_zero, o_err);
        end
        tick();
        total++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got rdy=%b v=%b, want rdy=1 v=0", o_ready, o_valid);
        end
    endtask

    task automatic test_logic();
        logic [7:0] exp_r [4];
        exp_r = '{8'h0F, 8'h30, 8'hFC, 8'hCC};
        i_ready = 1'b1; i_a = 8'hF0; i_b = 8'h3C;
        for (int c = 0; c < 6; c++) begin
            i_valid = (c < 4);
            i_op    = 3'(c);
            tick();
            total++;
            if (o_ready !== 1'b1) begin
                bad++;
                $display("FAIL logic_ready[%0d]: got %b, want 1", c, o_ready);
            end
            total++;
            if (c == 0 || c == 5) begin
                if (o_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL logic_idle[%0d]: got v=%b, want v=0", c, o_valid);
                end
            end else if (o_valid !== 1'b1 || o_result !== exp_r[c-1] || o_flag !== 1'b0 ||
                         o_zero !== 1'b0 || o_err !== 1'b0) begin
                bad++;
                $display("FAIL logic_op[%0d]: got v=%b r=%h f=%b z=%b e=%b, want v=1 r=%h f=0 z=0 e=0",
                         c - 1, o_valid, o_result, o_flag, o_zero, o_err, exp_r[c-1]);
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_compare();
        logic [2:0] ops   [3];
        logic [7:0] as    [3];
        logic [7:0] bs    [3];
        logic [7:0] exp_r [3];
        logic       exp_f [3];
        logic       exp_z [3];
        ops   = '{3'b100, 3'b110, 3'b101};
        as    = '{8'h05, 8'h05, 8'h00};
        bs    = '{8'h09, 8'h09, 8'h00};
        exp_r = '{8'h09, 8'h05, 8'h00};
        exp_f = '{1'b0, 1'b1, 1'b1};
        exp_z = '{1'b0, 1'b0, 1'b1};
        i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            i_valid = (c < 3);
            if (c < 3) begin
                i_op = ops[c]; i_a = as[c]; i_b = bs[c];
            end
            tick();
            if (c > 0) begin
                total++;
                if (o_valid !== 1'b1 || o_result !== exp_r[c-1] || o_flag !== exp_f[c-1] ||
                    o_zero !== exp_z[c-1] || o_err !== 1'b0) begin
                    bad++;
                    $display("FAIL compare[%0d]: got v=%b r=%h f=%b z=%b e=%b, want v=1 r=%h f=%b z=%b e=0",
                             c - 1, o_valid, o_result, o_flag, o_zero, o_err, exp_r[c-1], exp_f[c-1], exp_z[c-1]);
                end
            end
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_reserved();
        logic [2:0] ops   [2];
        logic [7:0] bs    [2];
        logic [7:0] exp_r [2];
        logic       exp_e [2];
        logic       exp_z [2];
        ops   = '{3'b111, 3'b001};
        bs    = '{8'hFF, 8'h0F};
        exp_r = '{8'h00, 8'h0F};
        exp_e = '{1'b1, 1'b0};
        exp_z = '{1'b1, 1'b0};
        i_ready = 1'b1; i_a = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            i_valid = (c < 2);
            if (c < 2) begin
                i_op = ops[c]; i_b = bs[c];
            end
            tick();
            if (c > 0) begin
                total++;
                if (o_valid !== 1'b1 || o_result !== exp_r[c-1] || o_err !== exp_e[c-1] ||
                    o_zero !== exp_z[c-1] || o_flag !== 1'b0) begin
                    bad++;
                    $display("FAIL reserved[%0d]: got v=%b r=%h e=%b z=%b f=%b, want v=1 r=%h e=%b z=%b f=0",
                             c - 1, o_valid, o_result, o_err, o_zero, o_flag, exp_r[c-1], exp_e[c-1], exp_z[c-1]);
                end
            end
        end
        i_valid = 1'b0;
        tick();
    endtask

`ifdef LOG_SIGNED_EN
    task automatic test_signed();
        logic       sg    [2];
        logic [7:0] exp_r [2];
        logic       exp_f [2];
        sg    = '{1'b1, 1'b0};
        exp_r = '{8'h01, 8'h80};
        exp_f = '{1'b0, 1'b1};
        i_ready = 1'b1; i_op = 3'b100; i_a = 8'h80; i_b = 8'h01;
        for (int c = 0; c < 3; c++) begin
            i_valid = (c < 2);
            if (c < 2) i_signed = sg[c];
            tick();
            if (c > 0) begin
                total++;
                if (o_valid !== 1'b1 || o_result !== exp_r[c-1] || o_flag !== exp_f[c-1]) begin
                    bad++;
                    $display("FAIL signed_max[%0d]: got v=%b r=%h f=%b, want v=1 r=%h f=%b",
                             c - 1, o_valid, o_result, o_flag, exp_r[c-1], exp_f[c-1]);
                end
            end
        end
        i_valid = 1'b0; i_signed = 1'b0;
        tick();
    endtask
`endif

    task automatic test_back_to_back();
        logic [2:0] ops   [4];
        logic [7:0] exp_r [4];
        logic [7:0] held;
        int sent = 0;
        int got  = 0;
        int stall = 0;
        int stall_cycles = 0;
        bit stalled = 1'b0;
        bit fire_in, fire_out;
        ops   = '{3'b001, 3'b010, 3'b011, 3'b000};
        exp_r = '{8'h30, 8'hFC, 8'hCC, 8'h0F};
        held  = 8'h00;
        i_a = 8'hF0; i_b = 8'h3C;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            i_valid = (sent < 4);
            if (sent < 4) i_op = ops[sent];
            if (o_valid && !stalled && stall == 0) begin
                stall = 5; stalled = 1'b1; held = o_result;
            end
            i_ready = (stall == 0);
            #1;
            if (stall > 0) begin
                stall_cycles++;
                total++;
                if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_result !== held) begin
                    bad++;
                    $display("FAIL stall_hold[%0d]: got rdy=%b v=%b r=%h, want rdy=0 v=1 r=%h",
                             cyc, o_ready, o_valid, o_result, held);
                end
                stall--;
            end
            fire_in  = i_valid && o_ready;
            fire_out = o_valid && i_ready;
            if (fire_out) begin
                total++;
                if (o_result !== exp_r[got]) begin
                    bad++;
                    $display("FAIL stream_order[%0d]: got r=%h, want r=%h", got, o_result, exp_r[got]);
                end
                got++;
            end
            tick();
            if (fire_in) sent++;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        total++;
        if (got !== 4 || stall_cycles !== 5) begin
            bad++;
            $display("FAIL stream_count: got results=%0d stalls=%0d, want results=4 stalls=5", got, stall_cycles);
        end
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_dup: got v=%b after last result, want v=0", o_valid);
        end
    endtask

    task automatic test_reset_midflight();
        i_ready = 1'b1; i_op = 3'b001; i_a = 8'hFF; i_b = 8'hFF;
        i_valid = 1'b1;
        tick();
        i_op = 3'b100;
        tick();
        total++;
        if (o_valid !== 1'b1 || o_result !== 8'hFF) begin
            bad++;
            $display("FAIL midflight_pre: got v=%b r=%h, want v=1 r=ff", o_valid, o_result);
        end
        i_valid = 1'b0; i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        total++;
        if (o_valid !== 1'b0 || o_result !== 8'h00 || o_flag !== 1'b0 || o_zero !== 1'b0 || o_err !== 1'b0) begin
            bad++;
            $display("FAIL midflight_reset: got v=%b r=%h f=%b z=%b e=%b, want all 0",
                     o_valid, o_result, o_flag, o_zero, o_err);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
                bad++;
                $display("FAIL midflight_stale[%0d]: got v=%b rdy=%b, want v=0 rdy=1", c, o_valid, o_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_compare();
        test_reserved();
`ifdef LOG_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
